// File: rtl/led_req_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : led_req_scheduler_if
// Brief    : Request/grant/LED bundle between requesters and the LED scheduler.
// Revision : 1.0
// ============================================================================
interface led_req_scheduler_if #(
    parameter int N_REQ = 4
) ();
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] Req;
    logic [N_REQ-1:0] Grant;
    logic             Done;
    logic [ID_W-1:0]  Done_Id;
    logic             Led;
    logic [1:0]       Estado_Salida;

    modport master (
        output Req,
        input  Grant,
        input  Done,
        input  Done_Id,
        input  Led,
        input  Estado_Salida
    );

    modport slave (
        input  Req,
        output Grant,
        output Done,
        output Done_Id,
        output Led,
        output Estado_Salida
    );
endinterface
`default_nettype wire

// File: rtl/led_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_req_scheduler
// Brief    : Round-robin sharing of one status LED: fixed on-window, fixed gap.
// Revision : 1.0
// ============================================================================
module led_req_scheduler #(
    parameter int N_REQ      = 4,
    parameter int ON_CYCLES  = 8,
    parameter int GAP_CYCLES = 2
) (
    input wire             Clk,
    input wire             Reset_n,
    led_req_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);

    localparam logic [7:0]       c_ON_LOAD  = 8'(ON_CYCLES - 1);
    localparam logic [7:0]       c_GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_win;
    logic [7:0]       r_cnt;
    logic [N_REQ-1:0] r_grant;
    logic             r_led;
    logic             r_done;
    logic [PTR_W-1:0] r_done_id;

    state_t           w_state;
    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] w_win;
    logic [7:0]       w_cnt;
    logic [N_REQ-1:0] w_grant;
    logic             w_led;
    logic             w_done;
    logic [PTR_W-1:0] w_done_id;

    logic             w_any;
    logic [PTR_W-1:0] w_arb_idx;
    logic [PTR_W-1:0] w_arb_next_ptr;
    logic [N_REQ-1:0] w_arb_onehot;

    // Round-robin search: first requester at or after r_ptr, wrapping.
    always_comb begin
        int v_j;
        v_j       = 0;
        w_any     = 1'b0;
        w_arb_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            v_j = int'(r_ptr) + i;
            if (v_j >= N_REQ) begin
                v_j = v_j - N_REQ;
            end
            if (!w_any && bus.Req[v_j]) begin
                w_any     = 1'b1;
                w_arb_idx = PTR_W'(v_j);
            end
        end
        w_arb_next_ptr = (w_arb_idx == c_PTR_LAST) ? '0 : w_arb_idx + 1'b1;
        w_arb_onehot   = {{(N_REQ-1){1'b0}}, 1'b1} << w_arb_idx;
    end

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_win     = r_win;
        w_cnt     = r_cnt;
        w_grant   = r_grant;
        w_led     = r_led;
        w_done    = 1'b0;
        w_done_id = '0;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state = S_ON;
                    w_grant = w_arb_onehot;
                    w_led   = 1'b1;
                    w_cnt   = c_ON_LOAD;
                    w_win   = w_arb_idx;
                    w_ptr   = w_arb_next_ptr;
                end
            end

            S_ON: begin
                // A withdrawn request ends the window early and earns no Done.
                if (!bus.Req[r_win]) begin
                    w_state = S_GAP;
                    w_grant = '0;
                    w_led   = 1'b0;
                    w_cnt   = c_GAP_LOAD;
                end else if (r_cnt == 8'd0) begin
                    w_state   = S_GAP;
                    w_grant   = '0;
                    w_led     = 1'b0;
                    w_cnt     = c_GAP_LOAD;
                    w_done    = 1'b1;
                    w_done_id = r_win;
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end

            S_GAP: begin
                if (r_cnt == 8'd0) begin
                    if (w_any) begin
                        w_state = S_ON;
                        w_grant = w_arb_onehot;
                        w_led   = 1'b1;
                        w_cnt   = c_ON_LOAD;
                        w_win   = w_arb_idx;
                        w_ptr   = w_arb_next_ptr;
                    end else begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_cnt = r_cnt - 8'd1;
                end
            end

            default: begin
                w_state = S_IDLE;
                w_grant = '0;
                w_led   = 1'b0;
                w_cnt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= 8'd0;
            r_grant   <= '0;
            r_led     <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= '0;
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_win     <= w_win;
            r_cnt     <= w_cnt;
            r_grant   <= w_grant;
            r_led     <= w_led;
            r_done    <= w_done;
            r_done_id <= w_done_id;
        end
    end

    assign bus.Grant         = r_grant;
    assign bus.Led           = r_led;
    assign bus.Done          = r_done;
    assign bus.Done_Id       = r_done_id;
    assign bus.Estado_Salida = r_state;
endmodule
`default_nettype wire

// File: tb/tb_led_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_req_scheduler
// Brief    : Directed and randomized checks of the LED scheduler against a model.
// Revision : 1.0
// ============================================================================
module tb_led_req_scheduler;
    localparam int N   = 4;
    localparam int ON  = 8;
    localparam int GAP = 2;

    logic Clk;
    logic Reset_n;

    led_req_scheduler_if #(.N_REQ(N)) bus ();
    led_req_scheduler_if #(.N_REQ(2)) bus2 ();

    led_req_scheduler #(.N_REQ(N), .ON_CYCLES(ON), .GAP_CYCLES(GAP)) u_dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    led_req_scheduler #(.N_REQ(2), .ON_CYCLES(1), .GAP_CYCLES(1)) u_dut_min (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // Model: phase 0 idle, 1 lit, 2 dark; m_elapsed counts cycles spent in phase.
    int         m_phase   = 0;
    int         m_owner   = 0;
    int         m_elapsed = 0;
    int         m_ptr     = 0;
    bit         e_done    = 1'b0;
    int         e_done_id = 0;
    logic [N-1:0] m_req;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    initial forever begin
        @(posedge Clk or negedge Reset_n);
        if (!Reset_n) begin
            m_phase = 0; m_owner = 0; m_elapsed = 0; m_ptr = 0;
            e_done = 1'b0; e_done_id = 0;
        end else begin
            m_req  = bus.Req;
            e_done = 1'b0;
            if (m_phase == 1) begin
                if (!m_req[m_owner]) begin
                    m_phase = 2; m_elapsed = 1;
                end else if (m_elapsed == ON) begin
                    e_done = 1'b1; e_done_id = m_owner;
                    m_phase = 2; m_elapsed = 1;
                end else begin
                    m_elapsed++;
                end
            end else if (m_phase == 2 && m_elapsed < GAP) begin
                m_elapsed++;
            end else if (m_req != '0) begin
                m_owner   = pick(m_req, m_ptr);
                m_ptr     = (m_owner + 1) % N;
                m_phase   = 1;
                m_elapsed = 1;
            end else begin
                m_phase = 0;
            end
        end
    end

    initial forever begin
        @(negedge Clk);
        if (cmp_en) begin
            chk("m_state", 32'(bus.Estado_Salida), 32'(m_phase));
            chk("m_led",   32'(bus.Led), (m_phase == 1) ? 32'd1 : 32'd0);
            chk("m_grant", 32'(bus.Grant), (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
            chk("m_done",  32'(bus.Done), 32'(e_done));
            if (e_done) chk("m_done_id", 32'(bus.Done_Id), 32'(e_done_id));
        end
    end

    task automatic do_reset();
        Reset_n = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic count_high(output int n);
        n = 0;
        while (bus.Led === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic count_low(output int n, output bit saw_idle);
        n = 0;
        saw_idle = 1'b0;
        while (bus.Led === 1'b0 && n < 40) begin
            if (bus.Estado_Salida == 2'd0) saw_idle = 1'b1;
            n++;
            tick();
        end
    endtask

    int n_len;
    bit idle_seen;

    initial begin
        Reset_n  = 1'b0;
        bus.Req  = 4'b1111;
        bus2.Req = 2'b00;
        tick();
        tick();
        tick();
        chk("rst_led",   32'(bus.Led), 32'd0);
        chk("rst_grant", 32'(bus.Grant), 32'd0);
        chk("rst_state", 32'(bus.Estado_Salida), 32'd0);
        chk("rst_done",  32'(bus.Done), 32'd0);
        bus.Req = '0;
        Reset_n = 1'b1;
        cmp_en  = 1'b1;
        tick();

        // Single request held
        do_reset();
        bus.Req = 4'b0100;
        tick();
        chk("single_grant", 32'(bus.Grant), 32'b0100);
        count_high(n_len);
        chk("single_on_len", 32'(n_len), 32'd8);
        chk("single_done",   32'(bus.Done), 32'd1);
        chk("single_done_id", 32'(bus.Done_Id), 32'd2);
        count_low(n_len, idle_seen);
        chk("single_gap_len", 32'(n_len), 32'd2);
        chk("single_regrant", 32'(bus.Grant), 32'b0100);
        bus.Req = '0;

        // Round robin, all held
        do_reset();
        bus.Req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            chk("rr_grant", 32'(bus.Grant), 32'd1 << (g % 4));
            if (g < 4) begin
                count_high(n_len);
                chk("rr_on_len",  32'(n_len), 32'd8);
                chk("rr_done_id", 32'(bus.Done_Id), 32'(g));
                count_low(n_len, idle_seen);
                chk("rr_gap_len", 32'(n_len), 32'd2);
                chk("rr_no_idle", 32'(idle_seen), 32'd0);
            end
        end
        bus.Req = '0;

        // Withdrawal after 3 lit cycles
        do_reset();
        bus.Req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wd_led_on", 32'(bus.Led), 32'd1);
        end
        bus.Req = '0;
        tick();
        chk("wd_led_off", 32'(bus.Led), 32'd0);
        chk("wd_no_done", 32'(bus.Done), 32'd0);
        chk("wd_gap1",    32'(bus.Estado_Salida), 32'd2);
        tick();
        chk("wd_gap2",    32'(bus.Estado_Salida), 32'd2);
        tick();
        chk("wd_idle",    32'(bus.Estado_Salida), 32'd0);

        // Late arrival of requester 3 during requester 0's window
        do_reset();
        bus.Req = 4'b0001;
        tick();
        tick();
        bus.Req = 4'b1001;
        count_high(n_len);
        chk("late_on_len", 32'(n_len), 32'd7);
        count_low(n_len, idle_seen);
        chk("late_gap_len", 32'(n_len), 32'd2);
        chk("late_grant3",  32'(bus.Grant), 32'b1000);
        bus.Req = '0;

        // Asynchronous reset in the middle of a window
        do_reset();
        bus.Req = 4'b0010;
        tick();
        tick();
        chk("async_pre_led", 32'(bus.Led), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("async_led",   32'(bus.Led), 32'd0);
        chk("async_grant", 32'(bus.Grant), 32'd0);
        chk("async_state", 32'(bus.Estado_Salida), 32'd0);
        tick();
        bus.Req = '0;
        Reset_n = 1'b1;

        // Minimum parameters: 1 on / 1 off, ids alternate
        do_reset();
        bus2.Req = 2'b11;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("min_led", 32'(bus2.Led), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 1) begin
                chk("min_done",    32'(bus2.Done), 32'd1);
                chk("min_done_id", 32'(bus2.Done_Id), 32'(((i - 1) / 2) % 2));
            end
        end
        bus2.Req = 2'b00;

        // Randomized request traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) bus.Req[b] = ~bus.Req[b];
            end
            tick();
        end
        bus.Req = '0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
